// File: rtl/clean_scheduler.sv
// clean_scheduler: range-hood working-time accumulator and timed self-clean sequencer.
// Optional feature macro CLEAN_ABORT_EN: when defined, clean_abort ends a running self-clean.
module clean_scheduler #(
  parameter int TICKS_PER_SEC = 100,
  parameter int CLEAN_SEC     = 180
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       fan_on,
  input  logic       is_standby,
  input  logic       clean_req,
  input  logic       clean_abort,
  output logic [5:0] working_hour,
  output logic [5:0] working_min,
  output logic [5:0] working_sec,
  output logic       cleaning,
  output logic [7:0] clean_remaining,
  output logic       clean_done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    CLEAN_LOAD = 8'(CLEAN_SEC);

  typedef enum logic [1:0] {
    S_TRACK    = 2'd0,
    S_CLEANING = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_cleaning;
  logic [7:0]    r_remaining;
  logic          r_done;

  logic          w_wrap;
  logic          w_sat;
  logic          w_start;
  logic          w_abort;
  logic [PW-1:0] w_presc_nx;
  logic [5:0]    w_hour_nx;
  logic [5:0]    w_min_nx;
  logic [5:0]    w_sec_nx;

`ifdef CLEAN_ABORT_EN
  assign w_abort = clean_abort;
`else
  logic w_unused_abort;
  assign w_unused_abort = clean_abort;
  assign w_abort        = 1'b0;
`endif

  assign w_wrap     = (r_presc == PRESC_LAST);
  assign w_presc_nx = w_wrap ? {PW{1'b0}} : r_presc + PW'(1);
  assign w_sat      = (r_hour == 6'd63) && (r_min == 6'd59) && (r_sec == 6'd59);
  assign w_start    = clean_req & is_standby & ~fan_on;

  // Next hh:mm:ss value for one counted second; saturation is applied by the caller.
  always_comb begin
    w_sec_nx  = r_sec;
    w_min_nx  = r_min;
    w_hour_nx = r_hour;
    if (r_sec == 6'd59) begin
      w_sec_nx = 6'd0;
      if (r_min == 6'd59) begin
        w_min_nx  = 6'd0;
        w_hour_nx = r_hour + 6'd1;
      end else begin
        w_min_nx = r_min + 6'd1;
      end
    end else begin
      w_sec_nx = r_sec + 6'd1;
    end
  end

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      r_state     <= S_TRACK;
      r_presc     <= {PW{1'b0}};
      r_hour      <= 6'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_cleaning  <= 1'b0;
      r_remaining <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_TRACK: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_state     <= S_CLEANING;
            r_presc     <= {PW{1'b0}};
            r_remaining <= CLEAN_LOAD;
            r_cleaning  <= 1'b1;
          end else if (fan_on) begin
            r_presc <= w_presc_nx;
            if (w_wrap && !w_sat) begin
              r_hour <= w_hour_nx;
              r_min  <= w_min_nx;
              r_sec  <= w_sec_nx;
            end
          end
        end
        S_CLEANING: begin
          // Abort is checked first so it beats a coincident final tick.
          if (w_abort) begin
            r_state     <= S_TRACK;
            r_presc     <= {PW{1'b0}};
            r_remaining <= 8'd0;
            r_cleaning  <= 1'b0;
          end else begin
            r_presc <= w_presc_nx;
            if (w_wrap) begin
              if (r_remaining == 8'd1) begin
                r_state     <= S_DONE;
                r_cleaning  <= 1'b0;
                r_remaining <= 8'd0;
                r_done      <= 1'b1;
                r_hour      <= 6'd0;
                r_min       <= 6'd0;
                r_sec       <= 6'd0;
              end else begin
                r_remaining <= r_remaining - 8'd1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_TRACK;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= S_TRACK;
          r_presc     <= {PW{1'b0}};
          r_cleaning  <= 1'b0;
          r_remaining <= 8'd0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign working_hour    = r_hour;
  assign working_min     = r_min;
  assign working_sec     = r_sec;
  assign cleaning        = r_cleaning;
  assign clean_remaining = r_remaining;
  assign clean_done      = r_done;

endmodule
